// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// PC arithmetic helpers and the {pc, instr} entry stored in the prefetch FIFO.
package fetch_unit_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; head is read combinationally from registered storage.
// Push into an empty FIFO is visible next cycle; flush beats push/pop; caller never overfills or underflows it.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  fetch_entry_t               push_dat_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output fetch_entry_t               head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: sequential imem requests, in-order responses buffered with PCs, redirect flush.
// Latency: request N, response N+1, if_valid N+2; issue stops once buffered + in-flight reaches DEPTH.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count;
   logic [CW:0]   credit_used;
   logic          req_fire, rsp_take, push, pop;
   fetch_entry_t  head, push_dat;

   // Credit covers both buffered entries and requests still in flight, so a push can never overflow.
   assign credit_used    = {1'b0, count} + {1'b0, outstanding_q};
   assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_take = imem_rsp_valid && (outstanding_q != '0);
   assign push     = rsp_take && (discard_q == '0) && !redirect_valid;
   assign push_dat = '{pc: resp_pc_q, instr: imem_rsp_data};

   assign if_valid = (count != '0) && !redirect_valid;
   assign pop      = if_valid && if_ready;
   assign if_instr = head.instr;
   assign if_pc    = head.pc;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = align_pc(redirect_pc);
         resp_pc_d  = align_pc(redirect_pc);
         discard_d  = outstanding_q - CW'(rsp_take);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
         if (push)     resp_pc_d  = resp_pc_q + PC_STEP;
         if (rsp_take && (discard_q != '0)) discard_d = discard_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redirect_valid),
      .count_o    (count),
      .head_o     (head)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable in-order memory, PC-stream reference model, directed scenarios.
module tb_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int chk = 0;
   int err = 0;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model plus reference model: the delivered stream must be consecutive
   // words from the last reset/redirect target, each carrying mem[pc].
   int          lat = 1;
   int          k   = 0;
   logic [31:0] qa[$];
   int          qd[$];
   logic [31:0] exp_req   = RPC;
   logic [31:0] exp_deliv = RPC;
   logic        hold_if   = 1'b0;
   logic        hold_req  = 1'b0;
   logic [31:0] hold_pc   = 32'h0;
   logic [31:0] hold_addr = 32'h0;

   always @(negedge clk) begin
      if (!rst) begin
         qa.delete();
         qd.delete();
         imem_rsp_valid = 1'b0;
         check("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
         exp_req   = RPC;
         exp_deliv = RPC;
         hold_if   = 1'b0;
         hold_req  = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         if (qa.size() > 0 && qd[0] == k + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(qa[0]);
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            qa.push_back(imem_req_addr);
            qd.push_back(k + 1 + lat);
         end
         if (redirect_valid) begin
            check("redir_if_valid", {31'h0, if_valid}, 32'h0);
            check("redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
            exp_req   = redirect_pc & 32'hFFFF_FFFC;
            exp_deliv = redirect_pc & 32'hFFFF_FFFC;
            hold_if   = 1'b0;
            hold_req  = 1'b0;
         end else begin
            if (hold_if) begin
               check("hold_if_valid", {31'h0, if_valid}, 32'h1);
               check("hold_if_pc", if_pc, hold_pc);
            end
            if (hold_req) begin
               check("hold_req_valid", {31'h0, imem_req_valid}, 32'h1);
               check("hold_req_addr", imem_req_addr, hold_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
               check("req_addr", imem_req_addr, exp_req);
               exp_req = exp_req + 32'd4;
            end
            if (if_valid && if_ready) begin
               check("if_pc", if_pc, exp_deliv);
               check("if_instr", if_instr, instr_of(exp_deliv));
               exp_deliv = exp_deliv + 32'd4;
            end
            hold_if   = if_valid && !if_ready;
            hold_pc   = if_pc;
            hold_req  = imem_req_valid && !imem_req_ready;
            hold_addr = imem_req_addr;
         end
      end
      k++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!if_valid && n < 40) begin
         tick();
         n++;
      end
      if (!if_valid) begin
         chk++;
         err++;
         $display("FAIL %s: timeout waiting for if_valid, got 0 expected 1", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [3:0] pat;

      // 1: reset state, first-fetch latency, streaming at 1 instr/cycle
      lat = 1; if_ready = 1'b1;
      do_reset();
      check("rst_if_valid", {31'h0, if_valid}, 32'h0);
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      rst = 1'b1; #1;
      check("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("t1_req_addr", imem_req_addr, 32'h0);
      tick();
      check("t1_lat_if_valid", {31'h0, if_valid}, 32'h0);
      for (int j = 0; j < 4; j++) begin
         tick();
         check("t1_if_valid", {31'h0, if_valid}, 32'h1);
         check("t1_if_pc", if_pc, 32'(4 * j));
         check("t1_if_instr", if_instr, instr_of(32'(4 * j)));
      end

      // 2: decode stall fills exactly DEPTH credits, then drains in order
      if_ready = 1'b0;
      do_reset();
      rst = 1'b1; #1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req_valid && imem_req_ready) n++;
         tick();
      end
      check("t2_req_count", 32'(n), 32'd4);
      check("t2_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("t2_if_pc_held", if_pc, 32'h0);
      if_ready = 1'b1; #1;
      for (int j = 0; j < 4; j++) begin
         check("t2_drain_pc", if_pc, 32'(4 * j));
         if (j == 1) begin
            check("t2_resume_valid", {31'h0, imem_req_valid}, 32'h1);
            check("t2_resume_addr", imem_req_addr, 32'd16);
         end
         tick();
      end

      // 3: redirect with 3 requests in flight on a 3-cycle memory
      lat = 3; if_ready = 1'b1;
      do_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; #1;
      check("t3_redir_if_valid", {31'h0, if_valid}, 32'h0);
      tick();
      redirect_valid = 1'b0; #1;
      check("t3_new_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("t3_new_req_addr", imem_req_addr, 32'h40);
      wait_valid("t3_first");
      check("t3_first_pc", if_pc, 32'h40);
      tick();
      wait_valid("t3_second");
      check("t3_second_pc", if_pc, 32'h44);

      // 4: request-ready toggling 1,0,0,1
      lat = 1; if_ready = 1'b1;
      do_reset();
      rst = 1'b1;
      pat = 4'b1001;
      for (int i = 0; i < 12; i++) begin
         imem_req_ready = pat[i % 4]; #1;
         if (i == 1 || i == 2) check("t4_stall_addr", imem_req_addr, 32'h4);
         tick();
      end
      imem_req_ready = 1'b1; #1;
      check("t4_next_addr", imem_req_addr, 32'd24);

      // 5: redirect coinciding with a push and a pop at count 2
      lat = 1; if_ready = 1'b0;
      do_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      check("t5_pre_if_valid", {31'h0, if_valid}, 32'h1);
      check("t5_pre_if_pc", if_pc, 32'h0);
      if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
      check("t5_redir_if_valid", {31'h0, if_valid}, 32'h0);
      tick();
      redirect_valid = 1'b0; #1;
      check("t5_flushed_if_valid", {31'h0, if_valid}, 32'h0);
      check("t5_new_addr", imem_req_addr, 32'h100);
      wait_valid("t5_first");
      check("t5_first_pc", if_pc, 32'h100);

      // 6: PC wrap, then reset mid-burst
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0; #1;
      wait_valid("t6_a");
      check("t6_wrap_a", if_pc, 32'hFFFF_FFF8);
      tick();
      wait_valid("t6_b");
      check("t6_wrap_b", if_pc, 32'hFFFF_FFFC);
      tick();
      wait_valid("t6_c");
      check("t6_wrap_c", if_pc, 32'h0000_0000);
      tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1; #1;
      check("t6_post_rst_if_valid", {31'h0, if_valid}, 32'h0);
      wait_valid("t6_rst");
      check("t6_post_rst_pc", if_pc, RPC);
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
